// File: rtl/qea_pkg.sv
// Shared definitions for the QEA readout path: amplitude constants, FSM states
// and lane slicing.
package qea_pkg;

  localparam logic [31:0] ONE = 32'h4000_0000;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  function automatic int lane_base(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/qea_readout_fifo.sv
// Synchronous first-word fall-through FIFO; the head entry is always visible on rdata.
module qea_readout_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/qea_state_readout.sv
// Sweeps the QEA state RAM after a circuit completes, streams |a|^2 per lane over
// valid/ready and accumulates the total probability.
module qea_state_readout
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int NUM_FRAC_BIT     = 30,
  parameter int RD_LAT           = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_complete,
  input  logic [MAX_QBIT_WIDTH-1:0]                      i_qbit_num,
  output logic [PE_NUM-1:0]                              o_state_ena,
  output logic [PE_NUM-1:0]                              o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]                    o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]             i_state_dout,
  output logic                                           o_prob_valid,
  input  logic                                           i_prob_ready,
  output logic [PE_NUM*DATA_WIDTH-1:0]                   o_prob_data,
  output logic [STATE_ADDR_WIDTH-1:0]                    o_prob_addr,
  output logic                                           o_prob_last,
  output logic [DATA_WIDTH+STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_norm,
  output logic                                           o_done,
  output logic                                           o_busy
);

  localparam int PROB_W = PE_NUM * DATA_WIDTH;
  localparam int FIFO_W = PROB_W + STATE_ADDR_WIDTH + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int NORM_W = DATA_WIDTH + STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int SQ_W   = 2 * DATA_WIDTH;

  state_t state, state_n;

  logic                        complete_q;
  logic                        start;
  logic                        issue;
  logic                        credit;
  logic                        push;
  logic                        pop;
  logic [STATE_ADDR_WIDTH-1:0] addr_cnt;
  logic [STATE_ADDR_WIDTH-1:0] last_addr;
  logic [STATE_ADDR_WIDTH-1:0] last_addr_calc;
  logic [MAX_QBIT_WIDTH-1:0]   n_eff;
  logic [STATE_ADDR_WIDTH:0]   word_cnt;
  logic [CNT_W-1:0]            inflight;
  logic [CNT_W-1:0]            fifo_count;
  logic [CNT_W:0]              occupancy;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [NORM_W-1:0]           norm;
  logic [NORM_W-1:0]           lane_total;

  logic [RD_LAT-1:0]           rd_vld;
  logic [STATE_ADDR_WIDTH-1:0] rd_addr [RD_LAT];

  logic [STATE_DATA_WIDTH-1:0] amp    [PE_NUM];
  logic signed [SQ_W-1:0]      re_ext [PE_NUM];
  logic signed [SQ_W-1:0]      im_ext [PE_NUM];

  logic                        s1_vld;
  logic [STATE_ADDR_WIDTH-1:0] s1_addr;
  logic [SQ_W-1:0]             s1_re_sq [PE_NUM];
  logic [SQ_W-1:0]             s1_im_sq [PE_NUM];

  logic [SQ_W:0]               sq_sum;
  logic [SQ_W:0]               shifted;
  logic [PROB_W-1:0]           s2_data_n;
  logic                        s2_vld;
  logic                        s2_last;
  logic [STATE_ADDR_WIDTH-1:0] s2_addr;
  logic [PROB_W-1:0]           s2_data;

  logic [FIFO_W-1:0]           fifo_rdata;

  for (genvar k = 0; k < PE_NUM; k++) begin : g_lane
    assign amp[k]    = i_state_dout[lane_base(k, STATE_DATA_WIDTH) +: STATE_DATA_WIDTH];
    assign re_ext[k] = {{DATA_WIDTH{amp[k][STATE_DATA_WIDTH-1]}}, amp[k][STATE_DATA_WIDTH-1 -: DATA_WIDTH]};
    assign im_ext[k] = {{DATA_WIDTH{amp[k][DATA_WIDTH-1]}}, amp[k][DATA_WIDTH-1:0]};
  end

  assign start = i_complete & ~complete_q & (state == IDLE);

  always_comb begin
    n_eff = i_qbit_num;
    if (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2))
      n_eff = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
    word_cnt = (STATE_ADDR_WIDTH + 1)'(1);
    if (n_eff > MAX_QBIT_WIDTH'(2))
      word_cnt = (STATE_ADDR_WIDTH + 1)'(1) << (n_eff - MAX_QBIT_WIDTH'(2));
    last_addr_calc = STATE_ADDR_WIDTH'(word_cnt - (STATE_ADDR_WIDTH + 1)'(1));
  end

  // A word leaving the FIFO this cycle frees its slot now, which keeps the
  // sweep at one word per cycle while still bounding occupancy by FIFO_DEPTH.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight} - (CNT_W + 1)'(pop);
  assign credit    = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE:  if (start) state_n = READ;
      READ: begin
        if (credit) begin
          issue = 1'b1;
          if (addr_cnt == last_addr) state_n = DRAIN;
        end
      end
      DRAIN: if (inflight == '0 && fifo_empty) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      complete_q <= 1'b0;
      addr_cnt   <= '0;
      last_addr  <= '0;
      inflight   <= '0;
      norm       <= '0;
      rd_vld     <= '0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
    end else begin
      state      <= state_n;
      complete_q <= i_complete;
      if (start) begin
        addr_cnt  <= '0;
        last_addr <= last_addr_calc;
        norm      <= '0;
      end else begin
        if (issue) addr_cnt <= addr_cnt + STATE_ADDR_WIDTH'(1);
        if (push)  norm <= norm + lane_total;
      end
      inflight  <= inflight + CNT_W'(issue) - CNT_W'(push);
      rd_vld[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
      s1_vld <= rd_vld[RD_LAT-1];
      s2_vld <= s1_vld;
    end
  end

  always_comb begin
    sq_sum    = '0;
    shifted   = '0;
    s2_data_n = '0;
    for (int unsigned k = 0; k < PE_NUM; k++) begin
      sq_sum  = {1'b0, s1_re_sq[k]} + {1'b0, s1_im_sq[k]};
      shifted = sq_sum >> NUM_FRAC_BIT;
      if (|shifted[SQ_W:DATA_WIDTH]) s2_data_n[k*DATA_WIDTH +: DATA_WIDTH] = '1;
      else                           s2_data_n[k*DATA_WIDTH +: DATA_WIDTH] = shifted[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    lane_total = '0;
    for (int unsigned k = 0; k < PE_NUM; k++)
      lane_total = lane_total + NORM_W'(s2_data[k*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk) begin
    rd_addr[0] <= addr_cnt;
    for (int unsigned i = 1; i < RD_LAT; i++) rd_addr[i] <= rd_addr[i-1];
    s1_addr <= rd_addr[RD_LAT-1];
    for (int unsigned k = 0; k < PE_NUM; k++) begin
      s1_re_sq[k] <= re_ext[k] * re_ext[k];
      s1_im_sq[k] <= im_ext[k] * im_ext[k];
    end
    s2_addr <= s1_addr;
    s2_data <= s2_data_n;
    s2_last <= (s1_addr == last_addr);
  end

  assign push = s2_vld;
  assign pop  = o_prob_valid & i_prob_ready;

  qea_readout_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({s2_last, s2_addr, s2_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_prob_valid  = ~fifo_empty;
  assign o_prob_last   = fifo_rdata[FIFO_W-1];
  assign o_prob_addr   = fifo_rdata[PROB_W +: STATE_ADDR_WIDTH];
  assign o_prob_data   = fifo_rdata[PROB_W-1:0];
  assign o_state_ena   = {PE_NUM{issue}};
  assign o_state_wea   = '0;
  assign o_state_addra = addr_cnt;
  assign o_norm        = norm;
  assign o_done        = (state == DONE);
  assign o_busy        = (state != IDLE);

endmodule
